// File: rtl/shift_deser_pkg.sv
// Shared definitions for the serial datapath family (shift register,
// transmitter and this deserializer).
//
// Contents:
//   DIR_MSB_FIRST / DIR_LSB_FIRST  bit-order encodings carried on lsb_first
//   bitOrder_e                     enum view of the same encoding
package shift_deser_pkg;

    // Bit-order encoding shared with the shift-register and transmitter blocks
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic {
        ORDER_MSB = DIR_MSB_FIRST,
        ORDER_LSB = DIR_LSB_FIRST
    } bitOrder_e;

endpackage

// File: rtl/shift_deser_if.sv
// Bus bundle between a serial source / parallel consumer and shift_deser.
//
// Signals:
//   ser_in, ser_valid, lsb_first, clear, out_ready   driven by the master
//   data_out, out_valid, overrun, bit_cnt            driven by the deserializer
// Modports:
//   master  the environment (serial source plus parallel consumer)
//   slave   the deserializer itself
interface shift_deser_if #(
    parameter int DATA_WIDTH = 4
) ();
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);

    logic                  ser_in;
    logic                  ser_valid;
    logic                  lsb_first;
    logic                  clear;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  out_valid;
    logic                  overrun;
    logic [CNT_WIDTH-1:0]  bit_cnt;

    modport master (
        output ser_in, ser_valid, lsb_first, clear, out_ready,
        input  data_out, out_valid, overrun, bit_cnt
    );

    modport slave (
        input  ser_in, ser_valid, lsb_first, clear, out_ready,
        output data_out, out_valid, overrun, bit_cnt
    );
endinterface

// File: rtl/shift_deser_bit_counter.sv
// Frame bit counter for the deserializer.
//
// Ports:
//   clk, n_rst   clock and asynchronous active-low reset
//   clear_i      synchronous flush back to bit 0
//   inc_i        a bit was accepted this cycle
//   bit_cnt_o    bits received so far in the current frame
//   last_bit_o   strobe: the accepted bit completes the frame
module deser_bit_counter #(
    parameter int DATA_WIDTH = 4,
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] bit_cnt_o,
    output logic                 last_bit_o
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // The frame ends when the final bit position is filled; the counter then
    // wraps to zero so the next accepted bit starts a fresh frame.
    assign last_bit_o = inc_i && (cnt_q == LAST_IDX);

    // Next count: flush wins, otherwise advance or wrap on each accepted bit
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = last_bit_o ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_cnt_o = cnt_q;

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: assembles DATA_WIDTH-bit words from a serial
// stream, MSB-first or LSB-first, and offers them on a valid/ready output.
//
// Ports:
//   clk, n_rst   clock and asynchronous active-low reset
//   bus          shift_deser_if slave modport:
//                  ser_in/ser_valid  serial bit and its qualifier
//                  lsb_first         bit order, taken on the first bit of a frame
//                  clear             synchronous abort/flush (highest priority)
//                  data_out          last completed word
//                  out_valid         data_out not yet consumed
//                  out_ready         consumer accepts data_out
//                  overrun           sticky: a completed word was dropped
//                  bit_cnt           bits received in the current frame
module shift_deser
    import shift_deser_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic           clk,
    input  logic           n_rst,
    shift_deser_if.slave   bus
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic                  order_q, order_d;
    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  outValid_q, outValid_d;
    logic                  overrun_q, overrun_d;

    logic [CNT_WIDTH-1:0]  bitCnt;
    logic                  lastBit;
    logic                  accept;
    logic                  frameStart;
    logic                  curOrder;
    logic [DATA_WIDTH-1:0] candidate;

    assign accept = bus.ser_valid && !bus.clear;

    deser_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_counter (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear_i    (bus.clear),
        .inc_i      (accept),
        .bit_cnt_o  (bitCnt),
        .last_bit_o (lastBit)
    );

    // The first bit of a frame uses lsb_first directly so the order is in
    // force from that bit on; later bits follow the latched copy.
    assign frameStart = (bitCnt == '0);
    assign curOrder   = frameStart ? bus.lsb_first : order_q;

    // Shifted image including the bit presented this cycle; on the last bit
    // this is the completed word.
    always_comb begin
        candidate = '0;
        if (curOrder == DIR_LSB_FIRST) begin
            candidate = {bus.ser_in, shiftReg_q[DATA_WIDTH-1:1]};
        end else begin
            candidate = {shiftReg_q[DATA_WIDTH-2:0], bus.ser_in};
        end
    end

    // Next-state for shifter, order latch and output handshake. Clear beats
    // everything but leaves data_out alone; a word completing while the
    // previous one is still unconsumed and not being taken is dropped.
    always_comb begin
        shiftReg_d = shiftReg_q;
        order_d    = order_q;
        dataOut_d  = dataOut_q;
        outValid_d = outValid_q;
        overrun_d  = overrun_q;

        if (bus.clear) begin
            shiftReg_d = '0;
            outValid_d = 1'b0;
            overrun_d  = 1'b0;
        end else begin
            if (accept) begin
                if (frameStart) begin
                    order_d = bus.lsb_first;
                end
                shiftReg_d = lastBit ? '0 : candidate;
            end

            if (lastBit) begin
                if (!outValid_q || bus.out_ready) begin
                    dataOut_d  = candidate;
                    outValid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else if (outValid_q && bus.out_ready) begin
                outValid_d = 1'b0;
            end
        end
    end

    // State registers; reset discards any partial frame
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shiftReg_q <= '0;
            order_q    <= DIR_MSB_FIRST;
            dataOut_q  <= '0;
            outValid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            shiftReg_q <= shiftReg_d;
            order_q    <= order_d;
            dataOut_q  <= dataOut_d;
            outValid_q <= outValid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.data_out  = dataOut_q;
    assign bus.out_valid = outValid_q;
    assign bus.overrun   = overrun_q;
    assign bus.bit_cnt   = bitCnt;

endmodule

// File: tb/tb_shift_deser.sv
// Self-checking bench for shift_deser: a directed vector table, a few
// hand-written multi-cycle sequences, and a randomized run against a
// word-level reference model.
module tb_shift_deser;

    localparam int W  = 4;
    localparam int CW = $clog2(W);

    logic clk;
    logic n_rst;

    shift_deser_if #(.DATA_WIDTH(W)) bus ();

    shift_deser #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic          serIn;
        logic          serValid;
        logic          lsbFirst;
        logic          clear;
        logic          outReady;
        logic [W-1:0]  expData;
        logic          expValid;
        logic          expOverrun;
        logic [CW-1:0] expCnt;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: bits of the current frame in arrival order
    logic         mBits[$];
    logic         mOrder;
    logic [W-1:0] mData;
    logic         mValid;
    logic         mOverrun;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag, input logic [W-1:0] d, input logic v,
                            input logic o, input logic [CW-1:0] c);
        checkOutput({tag, ".data_out"},  int'(bus.data_out),  int'(d));
        checkOutput({tag, ".out_valid"}, int'(bus.out_valid), int'(v));
        checkOutput({tag, ".overrun"},   int'(bus.overrun),   int'(o));
        checkOutput({tag, ".bit_cnt"},   int'(bus.bit_cnt),   int'(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic sv, input logic lf,
                                 input logic clr, input logic rdy);
        bus.ser_in    = s;
        bus.ser_valid = sv;
        bus.lsb_first = lf;
        bus.clear     = clr;
        bus.out_ready = rdy;
    endtask

    task automatic addVec(input logic s, input logic sv, input logic lf, input logic clr,
                          input logic rdy, input logic [W-1:0] d, input logic v,
                          input logic o, input logic [CW-1:0] c);
        vec_t t;
        t = '{s, sv, lf, clr, rdy, d, v, o, c};
        vecs.push_back(t);
    endtask

    // One clock of the reference model, from the inputs about to be sampled
    task automatic modelStep();
        logic [W-1:0] word;
        if (bus.clear) begin
            mBits.delete();
            mValid   = 1'b0;
            mOverrun = 1'b0;
        end else begin
            logic done;
            done = 1'b0;
            if (bus.ser_valid) begin
                if (mBits.size() == 0) mOrder = bus.lsb_first;
                mBits.push_back(bus.ser_in);
                if (mBits.size() == W) begin
                    word = '0;
                    for (int i = 0; i < W; i++) begin
                        if (mOrder) word[i] = mBits[i];
                        else        word[W-1-i] = mBits[i];
                    end
                    mBits.delete();
                    done = 1'b1;
                    if (!mValid || bus.out_ready) begin
                        mData  = word;
                        mValid = 1'b1;
                    end else begin
                        mOverrun = 1'b1;
                    end
                end
            end
            if (!done && mValid && bus.out_ready) mValid = 1'b0;
        end
    endtask

    // Send one serial bit per cycle (no gaps), out_ready held at rdy
    task automatic sendWord(input logic [W-1:0] w, input logic lf, input logic rdy);
        for (int i = W - 1; i >= 0; i--) begin
            applyStimulus(w[i], 1'b1, lf, 1'b0, rdy);
            tick();
        end
        applyStimulus(1'b0, 1'b0, lf, 1'b0, rdy);
    endtask

    initial begin
        int pulses;
        logic [W-1:0] seen[$];

        applyStimulus(0, 0, 0, 0, 0);
        n_rst = 1'b0;
        tick();
        tick();
        checkAll("reset", 4'b0000, 1'b0, 1'b0, 2'd0);
        n_rst = 1'b1;

        // Directed table: MSB frame, LSB frame with mid-frame order toggle,
        // overrun then clear then recovery
        addVec(1,1,0,0,0, 4'b0000,0,0,2'd1);
        addVec(0,1,0,0,0, 4'b0000,0,0,2'd2);
        addVec(1,1,0,0,0, 4'b0000,0,0,2'd3);
        addVec(1,1,0,0,0, 4'b1011,1,0,2'd0);
        addVec(0,0,0,0,1, 4'b1011,0,0,2'd0);
        addVec(1,1,1,0,0, 4'b1011,0,0,2'd1);
        addVec(0,1,0,0,0, 4'b1011,0,0,2'd2);
        addVec(1,1,0,0,0, 4'b1011,0,0,2'd3);
        addVec(1,1,1,0,0, 4'b1101,1,0,2'd0);
        addVec(0,0,0,0,1, 4'b1101,0,0,2'd0);
        addVec(1,1,0,0,0, 4'b1101,0,0,2'd1);
        addVec(0,1,0,0,0, 4'b1101,0,0,2'd2);
        addVec(1,1,0,0,0, 4'b1101,0,0,2'd3);
        addVec(1,1,0,0,0, 4'b1011,1,0,2'd0);
        addVec(0,1,0,0,0, 4'b1011,1,0,2'd1);
        addVec(1,1,0,0,0, 4'b1011,1,0,2'd2);
        addVec(0,1,0,0,0, 4'b1011,1,0,2'd3);
        addVec(1,1,0,0,0, 4'b1011,1,1,2'd0);
        addVec(1,1,0,1,1, 4'b1011,0,0,2'd0);
        addVec(0,1,0,0,0, 4'b1011,0,0,2'd1);
        addVec(0,1,0,0,0, 4'b1011,0,0,2'd2);
        addVec(1,1,0,0,0, 4'b1011,0,0,2'd3);
        addVec(1,1,0,0,0, 4'b0011,1,0,2'd0);
        addVec(0,0,0,0,1, 4'b0011,0,0,2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].serIn, vecs[i].serValid, vecs[i].lsbFirst,
                          vecs[i].clear, vecs[i].outReady);
            tick();
            checkAll($sformatf("vec%0d", i), vecs[i].expData, vecs[i].expValid,
                     vecs[i].expOverrun, vecs[i].expCnt);
        end

        // Gapped frame 0110 MSB-first: bit_cnt must hold across idle cycles
        begin
            logic [W-1:0] g;
            g = 4'b0110;
            for (int i = 0; i < W; i++) begin
                applyStimulus(g[W-1-i], 1'b1, 1'b0, 1'b0, 1'b0);
                tick();
                if (i < W - 1) begin
                    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                    for (int k = 0; k < 3; k++) begin
                        tick();
                        checkOutput("gap.bit_cnt", int'(bus.bit_cnt), i + 1);
                    end
                end
            end
            checkAll("gap.done", 4'b0110, 1'b1, 1'b0, 2'd0);
            applyStimulus(0, 0, 0, 0, 1);
            tick();
            checkOutput("gap.consume", int'(bus.out_valid), 0);
        end

        // Back-to-back frames with out_ready always high
        pulses = 0;
        for (int f = 0; f < 2; f++) begin
            logic [W-1:0] w;
            w = (f == 0) ? 4'b1111 : 4'b0001;
            for (int i = W - 1; i >= 0; i--) begin
                applyStimulus(w[i], 1'b1, 1'b0, 1'b0, 1'b1);
                tick();
                if (bus.out_valid) begin
                    pulses++;
                    seen.push_back(bus.data_out);
                end
            end
        end
        applyStimulus(0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (bus.out_valid) begin
                pulses++;
                seen.push_back(bus.data_out);
            end
        end
        checkOutput("b2b.pulses", pulses, 2);
        checkOutput("b2b.overrun", int'(bus.overrun), 0);
        checkOutput("b2b.word0", (seen.size() > 0) ? int'(seen[0]) : -1, 4'b1111);
        checkOutput("b2b.word1", (seen.size() > 1) ? int'(seen[1]) : -1, 4'b0001);

        // Asynchronous reset mid-frame, then a clean 1001 frame
        applyStimulus(1, 1, 0, 0, 0);
        tick();
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("prerst.bit_cnt", int'(bus.bit_cnt), 2);
        #2;
        n_rst = 1'b0;
        #1;
        checkAll("midrst", 4'b0000, 1'b0, 1'b0, 2'd0);
        #2;
        n_rst = 1'b1;
        sendWord(4'b1001, 1'b0, 1'b0);
        checkAll("postrst", 4'b1001, 1'b1, 1'b0, 2'd0);

        // Randomized run against the reference model
        n_rst = 1'b0;
        #2;
        n_rst = 1'b1;
        mBits.delete();
        mOrder   = 1'b0;
        mData    = '0;
        mValid   = 1'b0;
        mOverrun = 1'b0;
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(1, 0), ($urandom_range(9, 0) < 7),
                          $urandom_range(1, 0), ($urandom_range(39, 0) == 0),
                          ($urandom_range(2, 0) == 0));
            modelStep();
            tick();
            checkAll("rand", mData, mValid, mOverrun, CW'(mBits.size()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
